key_pt_router: RTL and testbench

Parametrised successor to the two-way key/plaintext selector: one stream of DATA_W-bit blocks enters on a single write port. The block classifies each block as a key or a plaintext, using a programmable key-reuse count, and forwards it to the key-expansion port or the cipher-core plaintext port. Unlike its predecessor, it supports:
- a forced rekey,
- back-pressure from the cipher core through a one-entry plaintext hold register,
- per-key plaintext counting and drop flagging.

It sits between the host/UART block assembler and the AES key schedule plus round core.

---
 rtl/key_pt_router_if.sv | 28 ++
 rtl/key_pt_router.sv | 141 ++++++++++++++
 tb/tb_key_pt_router.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/key_pt_router_if.sv
// Block stream in, key/plaintext streams out, between the block assembler and the AES key schedule / round core.
interface key_pt_router_if #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] block;
  logic              write_en;
  logic              rekey;
  logic              pt_ready;
  logic              in_ready;
  logic [DATA_W-1:0] key_block;
  logic              key_write;
  logic [DATA_W-1:0] pt_block;
  logic              pt_write;
  logic [CNT_W-1:0]  pt_count;
  logic              drop;
  logic              expect_key;

  modport master (
    output block, write_en, rekey, pt_ready,
    input  in_ready, key_block, key_write, pt_block, pt_write, pt_count, drop, expect_key
  );

  modport slave (
    input  block, write_en, rekey, pt_ready,
    output in_ready, key_block, key_write, pt_block, pt_write, pt_count, drop, expect_key
  );
endinterface

// File: rtl/key_pt_router.sv
// Classifies incoming blocks as key or plaintext by a programmable reuse count and forwards them.
// Keys/plaintexts appear one cycle after acceptance; a stalled plaintext parks in a one-entry hold and drops new writes.
module key_pt_router #(
  parameter int DATA_W     = 128,
  parameter int PT_PER_KEY = 1,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic reset,
  key_pt_router_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT_KEY = 2'd0,
    WAIT_PT  = 2'd1,
    PT_PEND  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              rekey_pend;
  logic [DATA_W-1:0] key_block_q;
  logic [DATA_W-1:0] pt_block_q;
  logic [CNT_W-1:0]  pt_count_q;
  logic              key_write_q;
  logic              pt_write_q;
  logic              drop_q;

  logic              in_ready_c;
  logic              expect_key_c;
  logic              load_key;
  logic              load_pt;
  logic              deliver;
  logic              drop_set;
  logic [CNT_W-1:0]  cnt_inc;
  logic              limit_hit;

  // Count limit is judged on the value the delivering edge will write.
  assign cnt_inc   = pt_count_q + 1'b1;
  assign limit_hit = (PT_PER_KEY != 0) && (cnt_inc == CNT_W'(PT_PER_KEY));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= WAIT_KEY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_KEY: begin
        if (bus.write_en) state_nxt = WAIT_PT;
      end
      WAIT_PT: begin
        // A rekey coincident with a write turns that block into the new key.
        if (bus.rekey) begin
          state_nxt = bus.write_en ? WAIT_PT : WAIT_KEY;
        end else if (bus.write_en) begin
          if (bus.pt_ready) state_nxt = limit_hit ? WAIT_KEY : WAIT_PT;
          else              state_nxt = PT_PEND;
        end
      end
      PT_PEND: begin
        if (bus.pt_ready) begin
          state_nxt = (rekey_pend || bus.rekey || limit_hit) ? WAIT_KEY : WAIT_PT;
        end
      end
      default: state_nxt = WAIT_KEY;
    endcase
  end

  always_comb begin
    in_ready_c   = 1'b0;
    expect_key_c = 1'b0;
    load_key     = 1'b0;
    load_pt      = 1'b0;
    deliver      = 1'b0;
    drop_set     = 1'b0;
    case (state)
      WAIT_KEY: begin
        in_ready_c   = 1'b1;
        expect_key_c = 1'b1;
        load_key     = bus.write_en;
      end
      WAIT_PT: begin
        in_ready_c = 1'b1;
        load_key   = bus.write_en && bus.rekey;
        load_pt    = bus.write_en && !bus.rekey;
        deliver    = bus.write_en && !bus.rekey && bus.pt_ready;
      end
      PT_PEND: begin
        deliver  = bus.pt_ready;
        drop_set = bus.write_en;
      end
      default: begin
        in_ready_c = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rekey_pend  <= 1'b0;
      key_block_q <= '0;
      pt_block_q  <= '0;
      pt_count_q  <= '0;
      key_write_q <= 1'b0;
      pt_write_q  <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      key_write_q <= load_key;
      pt_write_q  <= deliver;
      drop_q      <= drop_set;
      // A rekey seen while stalled survives until the held plaintext leaves.
      rekey_pend  <= (state == PT_PEND) && !bus.pt_ready && (rekey_pend || bus.rekey);
      if (load_key) begin
        key_block_q <= bus.block;
      end
      if (load_pt) begin
        pt_block_q <= bus.block;
      end
      if (load_key) begin
        pt_count_q <= '0;
      end else if (deliver) begin
        pt_count_q <= cnt_inc;
      end
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.expect_key = expect_key_c;
  assign bus.key_block  = key_block_q;
  assign bus.key_write  = key_write_q;
  assign bus.pt_block   = pt_block_q;
  assign bus.pt_write   = pt_write_q;
  assign bus.pt_count   = pt_count_q;
  assign bus.drop       = drop_q;

endmodule

// File: tb/tb_key_pt_router.sv
// Drives three routers (reuse counts 1, 3 and unlimited with a 4-bit counter) from one stimulus stream.
module tb_key_pt_router;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] blk_in = '0;
  logic          we_in = 1'b0;
  logic          rk_in = 1'b0;
  logic          rdy_in = 1'b0;

  always #5 clk = ~clk;

  key_pt_router_if #(.DATA_W(DW), .CNT_W(16)) if_a ();
  key_pt_router_if #(.DATA_W(DW), .CNT_W(16)) if_b ();
  key_pt_router_if #(.DATA_W(DW), .CNT_W(4))  if_c ();

  assign if_a.block = blk_in;  assign if_a.write_en = we_in;
  assign if_a.rekey = rk_in;   assign if_a.pt_ready = rdy_in;
  assign if_b.block = blk_in;  assign if_b.write_en = we_in;
  assign if_b.rekey = rk_in;   assign if_b.pt_ready = rdy_in;
  assign if_c.block = blk_in;  assign if_c.write_en = we_in;
  assign if_c.rekey = rk_in;   assign if_c.pt_ready = rdy_in;

  key_pt_router #(.DATA_W(DW), .PT_PER_KEY(1), .CNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  key_pt_router #(.DATA_W(DW), .PT_PER_KEY(3), .CNT_W(16)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));
  key_pt_router #(.DATA_W(DW), .PT_PER_KEY(0), .CNT_W(4))  dut_c (.clk(clk), .reset(reset), .bus(if_c.slave));

  logic [DW-1:0] o_key [3];
  logic [DW-1:0] o_pt  [3];
  logic [15:0]   o_cnt [3];
  logic          o_kw  [3];
  logic          o_pw  [3];
  logic          o_dr  [3];
  logic          o_ir  [3];
  logic          o_ek  [3];

  assign o_key[0] = if_a.key_block;  assign o_pt[0] = if_a.pt_block;  assign o_cnt[0] = if_a.pt_count;
  assign o_kw[0]  = if_a.key_write;  assign o_pw[0] = if_a.pt_write;  assign o_dr[0]  = if_a.drop;
  assign o_ir[0]  = if_a.in_ready;   assign o_ek[0] = if_a.expect_key;
  assign o_key[1] = if_b.key_block;  assign o_pt[1] = if_b.pt_block;  assign o_cnt[1] = if_b.pt_count;
  assign o_kw[1]  = if_b.key_write;  assign o_pw[1] = if_b.pt_write;  assign o_dr[1]  = if_b.drop;
  assign o_ir[1]  = if_b.in_ready;   assign o_ek[1] = if_b.expect_key;
  assign o_key[2] = if_c.key_block;  assign o_pt[2] = if_c.pt_block;  assign o_cnt[2] = {12'd0, if_c.pt_count};
  assign o_kw[2]  = if_c.key_write;  assign o_pw[2] = if_c.pt_write;  assign o_dr[2]  = if_c.drop;
  assign o_ir[2]  = if_c.in_ready;   assign o_ek[2] = if_c.expect_key;

  // Reference model: "want a key", "holding a plaintext", "rekey owed", plain integer count.
  int            ppk  [3] = '{1, 3, 0};
  int            cmod [3] = '{65536, 65536, 16};
  bit            m_wk [3];
  bit            m_pend [3];
  bit            m_rek [3];
  bit            m_kw [3];
  bit            m_pw [3];
  bit            m_dr [3];
  int            m_cnt [3];
  logic [DW-1:0] m_key [3];
  logic [DW-1:0] m_pt  [3];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_wk[i] = 1'b1; m_pend[i] = 1'b0; m_rek[i] = 1'b0;
      m_kw[i] = 1'b0; m_pw[i] = 1'b0; m_dr[i] = 1'b0;
      m_cnt[i] = 0; m_key[i] = '0; m_pt[i] = '0;
    end
  endfunction

  function automatic void deliver_pt(input int i);
    m_pw[i]  = 1'b1;
    m_cnt[i] = (m_cnt[i] + 1) % cmod[i];
    m_wk[i]  = m_rek[i] || (ppk[i] != 0 && m_cnt[i] == ppk[i]);
    m_rek[i] = 1'b0;
  endfunction

  function automatic void take_key(input int i);
    m_key[i] = blk_in; m_kw[i] = 1'b1; m_cnt[i] = 0; m_wk[i] = 1'b0;
  endfunction

  function automatic void model_step();
    for (int i = 0; i < 3; i++) begin
      m_kw[i] = 1'b0; m_pw[i] = 1'b0; m_dr[i] = 1'b0;
      if (m_pend[i]) begin
        if (rk_in) m_rek[i] = 1'b1;
        if (we_in) m_dr[i] = 1'b1;
        if (rdy_in) begin
          m_pend[i] = 1'b0;
          deliver_pt(i);
        end
      end else if (m_wk[i]) begin
        if (we_in) take_key(i);
      end else if (rk_in) begin
        if (we_in) take_key(i);
        else       m_wk[i] = 1'b1;
      end else if (we_in) begin
        m_pt[i] = blk_in;
        if (rdy_in) deliver_pt(i);
        else        m_pend[i] = 1'b1;
      end
    end
  endfunction

  task automatic check_outputs();
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("in_ready%0d", i),   DW'(o_ir[i]),  DW'(!m_pend[i]));
      check_val($sformatf("expect_key%0d", i), DW'(o_ek[i]),  DW'(!m_pend[i] && m_wk[i]));
      check_val($sformatf("key_write%0d", i),  DW'(o_kw[i]),  DW'(m_kw[i]));
      check_val($sformatf("pt_write%0d", i),   DW'(o_pw[i]),  DW'(m_pw[i]));
      check_val($sformatf("drop%0d", i),       DW'(o_dr[i]),  DW'(m_dr[i]));
      check_val($sformatf("pt_count%0d", i),   DW'(o_cnt[i]), DW'(m_cnt[i]));
      check_val($sformatf("key_block%0d", i),  o_key[i],      m_key[i]);
      check_val($sformatf("pt_block%0d", i),   o_pt[i],       m_pt[i]);
    end
  endtask

  // Called at a falling edge; inputs are applied, the rising edge is modelled, outputs checked at the next fall.
  task automatic cycle(input bit we, input bit rk, input bit rdy, input logic [DW-1:0] blk);
    we_in = we; rk_in = rk; rdy_in = rdy; blk_in = blk;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  // Reset rises between edges and must clear everything without waiting for a clock.
  task automatic do_reset();
    we_in = 1'b0; rk_in = 1'b0; rdy_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    check_val("rst_pt_write", DW'(o_pw[0]), '0);
    check_val("rst_expect_key", DW'(o_ek[0]), DW'(1));
    @(negedge clk);
    reset = 1'b0;
    check_outputs();
  endtask

  function automatic logic [DW-1:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam logic [DW-1:0] K1 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [DW-1:0] P1 = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [DW-1:0] K2 = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;
  localparam logic [DW-1:0] P2 = 128'hFF00FF00FF00FF00FF00FF00FF00FF00;

  initial begin
    logic [DW-1:0] held;
    model_reset();
    #1 reset = 1'b1;
    #1 check_outputs();
    @(negedge clk);
    reset = 1'b0;

    // Alternating key / plaintext with idle gaps
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, K1);
    check_val("t1_key_write", DW'(o_kw[0]), DW'(1));
    repeat (5) cycle(1'b0, 1'b0, 1'b1, '0);
    cycle(1'b1, 1'b0, 1'b1, P1);
    check_val("t1_pt_block", o_pt[0], P1);
    check_val("t1_pt_count", DW'(o_cnt[0]), DW'(1));
    repeat (5) cycle(1'b0, 1'b0, 1'b1, '0);
    cycle(1'b1, 1'b0, 1'b1, K2);
    check_val("t1_key2", o_key[0], K2);
    check_val("t1_cnt0", DW'(o_cnt[0]), '0);
    repeat (5) cycle(1'b0, 1'b0, 1'b1, '0);
    cycle(1'b1, 1'b0, 1'b1, P2);
    repeat (5) cycle(1'b0, 1'b0, 1'b1, '0);

    // Reuse count of three, back-to-back
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, K1);
    repeat (4) cycle(1'b1, 1'b0, 1'b1, rnd_blk());
    check_val("t2_key_after3", DW'(o_kw[1]), DW'(1));
    check_val("t2_cnt_after3", DW'(o_cnt[1]), '0);

    // Unlimited reuse, rekey coincident with a write, then counter wrap
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, K1);
    repeat (3) cycle(1'b1, 1'b0, 1'b1, rnd_blk());
    cycle(1'b1, 1'b1, 1'b1, K2);
    check_val("t3_key", o_key[2], K2);
    check_val("t3_no_pt", DW'(o_pw[2]), '0);
    repeat (20) cycle(1'b1, 1'b0, 1'b1, rnd_blk());
    check_val("t3_wrap_cnt", DW'(o_cnt[2]), DW'(4));

    // Stall with a dropped write
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, K1);
    cycle(1'b1, 1'b0, 1'b0, P1);
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, P2);
    check_val("t4_drop", DW'(o_dr[0]), DW'(1));
    check_val("t4_hold", o_pt[0], P1);
    check_val("t4_in_ready", DW'(o_ir[0]), '0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, '0);
    check_val("t4_pt_write", DW'(o_pw[0]), DW'(1));
    check_val("t4_ready_back", DW'(o_ir[0]), DW'(1));

    // Rekey while stalled
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, K1);
    cycle(1'b1, 1'b0, 1'b0, P1);
    cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, '0);
    check_val("t5_pt_write", DW'(o_pw[1]), DW'(1));
    check_val("t5_expect_key", DW'(o_ek[1]), DW'(1));

    // Reset while stalled discards the held plaintext
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, K1);
    cycle(1'b1, 1'b0, 1'b0, P1);
    cycle(1'b0, 1'b0, 1'b0, '0);
    do_reset();
    cycle(1'b0, 1'b0, 1'b1, '0);
    check_val("t6_no_pt_write", DW'(o_pw[0]), '0);

    // Random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      held = rnd_blk();
      cycle($urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7, held);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
